pipe_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core. It collects stall requests from the IF, ID, EX and MEM stages and drives the `stalled[5:0]` bus that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. It arbitrates redirects between branch resolution in EX and trap entry, and drives the flush/redirect pair that the PC register and if_id obey. A watchdog counter detects stalls that never release, which typically means the bus is hung.

---
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with trap burst and stall watchdog
// Combinational stall/branch paths; registered FSM, trap vector, burst counter and watchdog.
module pipe_ctrl #(
    parameter int STALL_TIMEOUT     = 255,
    parameter int TRAP_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_vec_i,
    output logic [5:0]  stalled_o,
    output logic        flush_o,
    output logic [31:0] flush_pc_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LIMIT = 16'(STALL_TIMEOUT);
    localparam logic [3:0]  TRAP_LOAD  = 4'(TRAP_FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_trap_cnt;
    logic [31:0] r_trap_vec;
    logic [15:0] r_wdog;
    logic        r_timeout;

    logic        w_any_req;
    logic        w_in_trap;
    logic [5:0]  w_stall_enc;
    logic        w_branch_ok;

    assign w_any_req = stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
    assign w_in_trap = (r_state == S_TRAP);

    // Highest requesting stage wins; wb is never frozen.
    always_comb begin
        w_stall_enc = 6'b000000;
        if (stallreq_mem_i)
            w_stall_enc = 6'b011111;
        else if (stallreq_ex_i)
            w_stall_enc = 6'b001111;
        else if (stallreq_id_i)
            w_stall_enc = 6'b000111;
        else if (stallreq_if_i)
            w_stall_enc = 6'b000011;
    end

    assign stalled_o = (!rst || w_in_trap) ? 6'b000000 : w_stall_enc;

    // A frozen EX stage keeps its branch and re-presents it once released.
    assign w_branch_ok = branch_flag_i && !w_in_trap && !w_stall_enc[3];

    always_comb begin
        flush_o    = 1'b0;
        flush_pc_o = 32'h0;
        if (rst) begin
            if (w_in_trap) begin
                flush_o    = 1'b1;
                flush_pc_o = r_trap_vec;
            end else if (w_branch_ok) begin
                flush_o    = 1'b1;
                flush_pc_o = branch_addr_i;
            end
        end
    end

    assign timeout_o = r_timeout;
    assign state_o   = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_trap_cnt <= 4'd0;
            r_trap_vec <= 32'h0;
        end else begin
            case (r_state)
                S_TRAP: begin
                    if (r_trap_cnt == 4'd0)
                        r_state <= w_any_req ? S_STALL : S_RUN;
                    else
                        r_trap_cnt <= r_trap_cnt - 4'd1;
                end
                default: begin
                    if (trap_req_i) begin
                        r_state    <= S_TRAP;
                        r_trap_vec <= trap_vec_i;
                        r_trap_cnt <= TRAP_LOAD;
                    end else begin
                        r_state <= w_any_req ? S_STALL : S_RUN;
                    end
                end
            endcase
        end
    end

    // Watchdog holds its count during a trap burst and saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog    <= 16'd0;
            r_timeout <= 1'b0;
        end else if (!w_any_req) begin
            r_wdog <= 16'd0;
        end else if (!w_in_trap && (r_wdog != WDOG_LIMIT)) begin
            r_wdog <= r_wdog + 16'd1;
            if (r_wdog == WDOG_LIMIT - 16'd1)
                r_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if_i = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_vec_i = 32'h0;
    logic [5:0]  stalled_o;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic        timeout_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_TIMEOUT(4), .TRAP_FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
        .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
        .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
        .stalled_o(stalled_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o),
        .timeout_o(timeout_o), .state_o(state_o)
    );

    // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
        branch_flag_i = 0; branch_addr_i = 0; trap_req_i = 0; trap_vec_i = 0;
    endtask

    task automatic test_reset();
        rst = 0; stallreq_mem_i = 1;
        tick(); #1;
        checks++; if (stalled_o !== 6'b0) begin errors++; $display("FAIL reset_stalled got %b want 000000", stalled_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
        checks++; if (flush_pc_o !== 32'h0) begin errors++; $display("FAIL reset_flush_pc got %h want 0", flush_pc_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        clear_inputs();
        tick(); rst = 1;
        tick();
    endtask

    task automatic test_priority();
        stallreq_if_i = 1; #1;
        checks++; if (stalled_o !== 6'b000011) begin errors++; $display("FAIL prio_if got %b want 000011", stalled_o); end
        stallreq_mem_i = 1; #1;
        checks++; if (stalled_o !== 6'b011111) begin errors++; $display("FAIL prio_mem got %b want 011111", stalled_o); end
        stallreq_mem_i = 0; stallreq_ex_i = 1; #1;
        checks++; if (stalled_o !== 6'b001111) begin errors++; $display("FAIL prio_ex got %b want 001111", stalled_o); end
        stallreq_ex_i = 0; stallreq_id_i = 1; #1;
        checks++; if (stalled_o !== 6'b000111) begin errors++; $display("FAIL prio_id got %b want 000111", stalled_o); end
        tick(); #1;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL prio_state_stall got %0d want 1", state_o); end
        clear_inputs(); #1;
        checks++; if (stalled_o !== 6'b0) begin errors++; $display("FAIL prio_release got %b want 000000", stalled_o); end
        tick(); #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL prio_state_run got %0d want 0", state_o); end
    endtask

    task automatic test_branch();
        tick();
        stallreq_id_i = 1; branch_flag_i = 1; branch_addr_i = 32'h0000_0100; #1;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL br_id_flush got %b want 1", flush_o); end
        checks++; if (flush_pc_o !== 32'h100) begin errors++; $display("FAIL br_id_pc got %h want 00000100", flush_pc_o); end
        stallreq_ex_i = 1; #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL br_ex_gate got %b want 0", flush_o); end
        stallreq_ex_i = 0; stallreq_id_i = 0; stallreq_mem_i = 1; #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL br_mem_gate got %b want 0", flush_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_trap_burst();
        trap_req_i = 1; trap_vec_i = 32'h8000_0004; #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL trap_req_cycle_flush got %b want 0", flush_o); end
        tick();
        trap_req_i = 0; trap_vec_i = 0; stallreq_mem_i = 1; #1;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL trap_c1_flush got %b want 1", flush_o); end
        checks++; if (flush_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL trap_c1_pc got %h want 80000004", flush_pc_o); end
        checks++; if (stalled_o !== 6'b0) begin errors++; $display("FAIL trap_c1_stalled got %b want 000000", stalled_o); end
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL trap_c1_state got %0d want 2", state_o); end
        tick(); #1;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL trap_c2_flush got %b want 1", flush_o); end
        checks++; if (flush_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL trap_c2_pc got %h want 80000004", flush_pc_o); end
        checks++; if (stalled_o !== 6'b0) begin errors++; $display("FAIL trap_c2_stalled got %b want 000000", stalled_o); end
        tick(); #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL trap_end_flush got %b want 0", flush_o); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL trap_end_state got %0d want 1", state_o); end
        checks++; if (stalled_o !== 6'b011111) begin errors++; $display("FAIL trap_end_stalled got %b want 011111", stalled_o); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_trap_vs_branch();
        trap_req_i = 1; trap_vec_i = 32'h0000_0A00; branch_flag_i = 1; branch_addr_i = 32'h0000_0200; #1;
        checks++; if (flush_o !== 1'b1 || flush_pc_o !== 32'h200) begin errors++; $display("FAIL tvb_branch got %b/%h want 1/00000200", flush_o, flush_pc_o); end
        tick();
        trap_req_i = 0; branch_addr_i = 32'h0000_0300; #1;
        checks++; if (flush_pc_o !== 32'h0A00 || state_o !== 2'd2) begin errors++; $display("FAIL tvb_c1 got %h/%0d want 00000a00/2", flush_pc_o, state_o); end
        tick();
        trap_req_i = 1; trap_vec_i = 32'h0000_0B00; #1;
        checks++; if (flush_pc_o !== 32'h0A00) begin errors++; $display("FAIL tvb_c2_pc got %h want 00000a00", flush_pc_o); end
        tick(); #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL b2b_last_ignored got %0d want 0", state_o); end
        checks++; if (flush_o !== 1'b1 || flush_pc_o !== 32'h300) begin errors++; $display("FAIL b2b_run_branch got %b/%h want 1/00000300", flush_o, flush_pc_o); end
        tick();
        clear_inputs(); #1;
        checks++; if (state_o !== 2'd2 || flush_pc_o !== 32'h0B00) begin errors++; $display("FAIL b2b_accepted got %0d/%h want 2/00000b00", state_o, flush_pc_o); end
        tick(); tick(); #1;
        checks++; if (state_o !== 2'd0 || flush_o !== 1'b0) begin errors++; $display("FAIL b2b_done got %0d/%b want 0/0", state_o, flush_o); end
    endtask

    task automatic test_watchdog();
        stallreq_mem_i = 1;
        tick(); tick(); tick();
        stallreq_mem_i = 0; #1;
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL wd_after3 got %b want 0", timeout_o); end
        tick();
        stallreq_mem_i = 1;
        tick(); tick(); tick(); #1;
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL wd_third_of4 got %b want 0", timeout_o); end
        tick(); #1;
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_fourth got %b want 1", timeout_o); end
        checks++; if (stalled_o !== 6'b011111) begin errors++; $display("FAIL wd_stall_kept got %b want 011111", stalled_o); end
        stallreq_mem_i = 0;
        tick(); tick(); #1;
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b want 1", timeout_o); end
    endtask

    task automatic test_reset_mid_burst();
        trap_req_i = 1; trap_vec_i = 32'h0000_0C00;
        tick();
        trap_req_i = 0; #1;
        checks++; if (flush_o !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL rmb_in_trap got %b/%0d want 1/2", flush_o, state_o); end
        rst = 0; #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rmb_flush got %b want 0", flush_o); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rmb_state got %0d want 0", state_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rmb_timeout got %b want 0", timeout_o); end
        tick(); rst = 1;
        tick(); #1;
        checks++; if (flush_o !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL rmb_after1 got %b/%0d want 0/0", flush_o, state_o); end
        tick(); #1;
        checks++; if (flush_o !== 1'b0 || flush_pc_o !== 32'h0) begin errors++; $display("FAIL rmb_after2 got %b/%h want 0/0", flush_o, flush_pc_o); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_branch();
        test_trap_burst();
        test_trap_vs_branch();
        test_watchdog();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
